// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and helpers for the multi-channel clock divider
//
// Purpose : constants and the half-period helper used by every divider channel.
// Contents: MIN_DIV  - smallest divisor that produces a running output
//           CH_IDX_W - width of the channel index on the write bus
//           ceil_half(D) - number of high cycles in a period of D cycles
package clk_div_pkg;

  localparam int MIN_DIV  = 2;
  localparam int CH_IDX_W = 3;

  // High phase gets the extra cycle for odd divisors (D=5 -> 3 high, 2 low).
  function automatic int unsigned ceil_half(input int unsigned d);
    return d - (d >> 1);
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// rtl/clk_div_multi_if.sv - divisor write / sync bus for the multi-channel clock divider
//
// Purpose : groups the control inputs of clk_div_multi.
// Signals : wr_en  - divisor write strobe
//           wr_ch  - target channel index (out-of-range indices are ignored)
//           wr_div - new divisor value
//           sync   - restart every channel at count 0
// Modports: master drives the bus, slave (the divider) receives it.
interface clk_div_multi_if
  import clk_div_pkg::*;
#(
  parameter int DIV_W = 8
);

  logic                wr_en;
  logic [CH_IDX_W-1:0] wr_ch;
  logic [DIV_W-1:0]    wr_div;
  logic                sync;

  modport master (output wr_en, output wr_ch, output wr_div, output sync);
  modport slave  (input  wr_en, input  wr_ch, input  wr_div, input  sync);

endinterface

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one programmable clock divider channel
//
// Purpose : divides clk_in by a runtime divisor, glitch-free divisor changes.
// Ports   : clk_in  in  - clock, rising edge
//           reset   in  - asynchronous active-low reset
//           wr      in  - load wr_div into the shadow divisor
//           wr_div  in  - new divisor
//           sync    in  - restart the period at count 0
//           clk_out out - divided clock, registered
//           tick    out - one-cycle strobe at the start of each high phase
import clk_div_pkg::*;

module clk_div_chan #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 12
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic             sync,
  output logic             clk_out,
  output logic             tick
);

  logic [DIV_W-1:0] shadow, active, cnt;
  logic [DIV_W-1:0] shadow_nx, active_nx, cnt_nx;
  logic             en_cur, en_nx, clk_nx, tick_nx;

  always_comb begin
    shadow_nx = shadow;
    active_nx = active;
    cnt_nx    = cnt;
    en_cur    = (active >= DIV_W'(MIN_DIV));

    if (wr) begin
      shadow_nx = wr_div;
    end

    // Period boundary: sync, a disabled channel, or the last count of the period.
    // The pre-write shadow is loaded, so a write landing on a boundary edge
    // takes effect one period later.
    if (sync || !en_cur || (cnt == active - DIV_W'(1))) begin
      cnt_nx    = '0;
      active_nx = shadow;
    end else begin
      cnt_nx    = cnt + DIV_W'(1);
    end

    en_nx   = (active_nx >= DIV_W'(MIN_DIV));
    clk_nx  = en_nx && (32'(cnt_nx) < ceil_half(32'(active_nx)));
    tick_nx = en_nx && (cnt_nx == '0);
  end

  // cnt starts at DEFAULT_DIV-1 so the first edge after reset wraps and
  // begins a high phase immediately.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      shadow  <= DIV_W'(DEFAULT_DIV);
      active  <= DIV_W'(DEFAULT_DIV);
      cnt     <= DIV_W'(DEFAULT_DIV - 1);
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      shadow  <= shadow_nx;
      active  <= active_nx;
      cnt     <= cnt_nx;
      clk_out <= clk_nx;
      tick    <= tick_nx;
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider
//
// Purpose : NUM_CH independent divided clocks from clk_in, each with its own
//           runtime divisor and tick strobe; sync phase-aligns all channels.
// Ports   : clk_in  in  - single clock, rising edge
//           reset   in  - asynchronous active-low reset
//           bus     slv - wr_en / wr_ch / wr_div / sync control bus
//           clk_out out - NUM_CH divided clocks, registered
//           tick    out - NUM_CH one-cycle strobes at each high-phase start
import clk_div_pkg::*;

module clk_div_multi #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 12
) (
  input  logic              clk_in,
  input  logic              reset,
  clk_div_multi_if.slave    bus,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] wr;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Indices at or above NUM_CH match no channel and are dropped.
    assign wr[i] = bus.wr_en && (bus.wr_ch == CH_IDX_W'(i));

    clk_div_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in  (clk_in),
      .reset   (reset),
      .wr      (wr[i]),
      .wr_div  (bus.wr_div),
      .sync    (bus.sync),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - self-checking bench for clk_div_multi
module tb_clk_div_multi;

  localparam int NUM_CH      = 4;
  localparam int DIV_W       = 8;
  localparam int DEFAULT_DIV = 12;

  logic              clk_in = 1'b0;
  logic              reset  = 1'b0;
  logic [NUM_CH-1:0] clk_out, tick;

  clk_div_multi_if #(.DIV_W(DIV_W)) bus ();

  clk_div_multi #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .bus     (bus.slave),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: each channel remembers when its current period started
  // (edge number) and how long it is; outputs follow from the age of the period.
  int shadow [NUM_CH];
  int plen   [NUM_CH];
  int pstart [NUM_CH];
  int e;
  int checks, passes, fails;
  logic [NUM_CH-1:0] exp_clk, exp_tick;

  task automatic check(input string tag, input logic [NUM_CH-1:0] got, input logic [NUM_CH-1:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s edge=%0d t=%0t got=%b exp=%b", tag, e, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      shadow[c] = DEFAULT_DIV;
      plen[c]   = DEFAULT_DIV;
      pstart[c] = e + 1 - DEFAULT_DIV;
    end
    exp_clk  = '0;
    exp_tick = '0;
  endtask

  task automatic model_edge(input logic we, input int wc, input int wd, input logic sy);
    int age;
    e++;
    for (int c = 0; c < NUM_CH; c++) begin
      age = e - pstart[c];
      if (sy || plen[c] < 2 || age >= plen[c]) begin
        pstart[c] = e;
        plen[c]   = shadow[c];
      end
      if (we && wc == c) shadow[c] = wd;
      age         = e - pstart[c];
      exp_clk[c]  = (plen[c] >= 2) && (age < (plen[c] + 1) / 2);
      exp_tick[c] = (plen[c] >= 2) && (age == 0);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    if (reset) model_edge(bus.wr_en, int'(bus.wr_ch), int'(bus.wr_div), bus.sync);
    else begin
      exp_clk  = '0;
      exp_tick = '0;
    end
    #1;
    check("clk_out", clk_out, exp_clk);
    check("tick", tick, exp_tick);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic write(input int ch, input int d);
    bus.wr_en  = 1'b1;
    bus.wr_ch  = 3'(ch);
    bus.wr_div = 8'(d);
    step();
    bus.wr_en  = 1'b0;
  endtask

  task automatic sync_pulse();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
  endtask

  initial begin
    int guard;
    int r;
    checks = 0; passes = 0; fails = 0; e = 0;
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_div = '0; bus.sync = 1'b0;
    model_reset();

    // Reset held ~100 ns: outputs stay low.
    idle(10);
    reset = 1'b1;
    model_reset();
    idle(30);

    // ch1 -> 5 mid-period.
    idle(3);
    write(1, 5);
    idle(30);

    // ch2 disabled, then restarted at divisor 2.
    write(2, 0);
    idle(20);
    write(2, 2);
    idle(10);

    // ch3 -> 7, run out of phase, then a one-cycle sync.
    write(3, 7);
    idle(15);
    sync_pulse();
    check("sync_tick_all", tick, {NUM_CH{1'b1}} & ~(4'b0100 & {4{plen[2] < 2}}));
    idle(10);

    // sync held three cycles together with a write on the first sync edge.
    bus.sync = 1'b1;
    write(0, 9);
    idle(2);
    bus.sync = 1'b0;
    idle(25);

    // Out-of-range channel index ignored.
    write(5, 3);
    write(7, 4);
    idle(30);

    // Write landing exactly on ch0's wrap edge.
    guard = 0;
    while ((e + 1 - pstart[0]) != plen[0] && guard < 300) begin
      step();
      guard++;
    end
    checks++;
    assert (guard < 300) passes++;
    else begin
      fails++;
      $error("FAIL wrap_search got=%0d exp<300", guard);
    end
    write(0, 6);
    idle(40);

    // Asynchronous reset in a high phase of ch0.
    guard = 0;
    while (!exp_clk[0] && guard < 300) begin
      step();
      guard++;
    end
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_clk", clk_out, '0);
    check("async_rst_tick", tick, '0);
    idle(3);
    reset = 1'b1;
    model_reset();
    step();
    check("rst_release_tick", tick, {NUM_CH{1'b1}});
    idle(25);

    // Randomized writes and syncs.
    for (int k = 0; k < 900; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 15) begin
        bus.wr_en  = 1'b1;
        bus.wr_ch  = 3'($urandom_range(0, 7));
        bus.wr_div = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 1))
                                                 : 8'($urandom_range(2, 20));
      end
      bus.sync = (r >= 97);
      step();
      bus.wr_en = 1'b0;
      bus.sync  = 1'b0;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
